// File: rtl/pipe_div_pkg.sv
// Shared constants and the single restoring-division step used by every
// pipe_divider stage.
package pipe_div_pkg;

  localparam int PIPE_DIV_DW   = 16;
  localparam int PIPE_DIV_VW   = 8;
  localparam int PIPE_DIV_TW   = 4;
  // Step operands are zero-extended to this width so one function serves any VW < 64.
  localparam int PIPE_DIV_MAXW = 64;

  typedef logic [PIPE_DIV_MAXW-1:0] pipe_div_word_t;

  // Returns {q, r'}: shifts dbit into r and subtracts divisor when it fits.
  function automatic logic [PIPE_DIV_MAXW:0] pipe_div_step(
    input pipe_div_word_t r,
    input logic           dbit,
    input pipe_div_word_t divisor
  );
    logic [PIPE_DIV_MAXW:0] t;
    t = {r, dbit};
    if (t >= {1'b0, divisor}) begin
      return {1'b1, t[PIPE_DIV_MAXW-1:0] - divisor};
    end
    return {1'b0, t[PIPE_DIV_MAXW-1:0]};
  endfunction

endpackage

// File: rtl/pipe_div_stage.sv
// One pipe_divider stage: resolves quotient bit DW-1-IDX and registers the
// operation state; all stages advance together on adv.
module pipe_div_stage
  import pipe_div_pkg::*;
#(
  parameter int DW      = PIPE_DIV_DW,
  parameter int VW      = PIPE_DIV_VW,
  parameter int TW      = PIPE_DIV_TW,
  parameter int IDX     = 0,
  parameter bit STORE_R = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          in_valid,
  input  logic [VW-1:0] in_r,
  input  logic [DW-1:0] in_dividend,
  input  logic [VW-1:0] in_divisor,
  input  logic [DW-1:0] in_quot,
  input  logic          in_div0,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  output logic [VW-1:0] out_r,
  output logic [DW-1:0] out_dividend,
  output logic [VW-1:0] out_divisor,
  output logic [DW-1:0] out_quot,
  output logic          out_div0,
  output logic [TW-1:0] out_tag
);

  localparam int BIT = DW - 1 - IDX;

  logic [PIPE_DIV_MAXW:0] step;
  logic                   q_bit;
  logic [VW-1:0]          r_next;

  logic          valid_q,    valid_d;
  logic [DW-1:0] dividend_q, dividend_d;
  logic [VW-1:0] divisor_q,  divisor_d;
  logic [DW-1:0] quot_q,     quot_d;
  logic          div0_q,     div0_d;
  logic [TW-1:0] tag_q,      tag_d;

  // A zero divisor always compares true, so r' is t truncated to VW bits.
  always_comb begin
    step   = pipe_div_step(pipe_div_word_t'(in_r), in_dividend[BIT],
                           pipe_div_word_t'(in_divisor));
    q_bit  = step[PIPE_DIV_MAXW];
    r_next = step[VW-1:0];
  end

  // NOTE: every variable gets its hold value first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    valid_d    = valid_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    div0_d     = div0_q;
    tag_d      = tag_q;
    if (adv) begin
      valid_d     = in_valid;
      dividend_d  = in_dividend;
      divisor_d   = in_divisor;
      quot_d      = in_quot;
      quot_d[BIT] = q_bit;
      div0_d      = in_div0;
      tag_d       = in_tag;
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage
  // samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      div0_q     <= 1'b0;
      tag_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      div0_q     <= div0_d;
      tag_q      <= tag_d;
    end
  end

  generate
    if (STORE_R) begin : g_r
      logic [VW-1:0] r_q, r_d;

      always_comb begin
        r_d = r_q;
        if (adv) r_d = r_next;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '0;
        else        r_q <= r_d;
      end

      assign out_r = r_q;
    end else begin : g_no_r
      assign out_r = '0;
    end
  endgenerate

  assign out_valid    = valid_q;
  assign out_dividend = dividend_q;
  assign out_divisor  = divisor_q;
  assign out_quot     = quot_q;
  assign out_div0     = div0_q;
  assign out_tag      = tag_q;

endmodule

// File: rtl/pipe_divider.sv
// Fully pipelined unsigned restoring divider, one quotient bit per stage.
// Define PIPE_DIV_REM_EN to add the out_remainder port.
module pipe_divider
  import pipe_div_pkg::*;
#(
  parameter int DW = PIPE_DIV_DW,
  parameter int VW = PIPE_DIV_VW,
  parameter int TW = PIPE_DIV_TW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_dividend,
  input  logic [VW-1:0] in_divisor,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_quotient,
`ifdef PIPE_DIV_REM_EN
  output logic [VW-1:0] out_remainder,
`endif
  output logic          out_div0,
  output logic [TW-1:0] out_tag
);

  // Index 0 is the operand interface; index k+1 is the register set of stage k.
  logic [DW:0]   vld;
  logic [VW-1:0] rem [DW+1];
  logic [DW-1:0] dvd [DW+1];
  logic [VW-1:0] dvs [DW+1];
  logic [DW-1:0] quo [DW+1];
  logic [DW:0]   dz;
  logic [TW-1:0] tag [DW+1];
  logic          adv;

  // The whole pipe freezes while a result waits, so in_ready follows out_ready.
  assign adv      = !vld[DW] || out_ready;
  assign in_ready = adv;

  assign vld[0] = in_valid;
  assign rem[0] = '0;
  assign dvd[0] = in_dividend;
  assign dvs[0] = in_divisor;
  assign quo[0] = '0;
  assign dz[0]  = (in_divisor == '0);
  assign tag[0] = in_tag;

  generate
    for (genvar k = 0; k < DW; k++) begin : g_stage
`ifdef PIPE_DIV_REM_EN
      localparam bit STORE_R = 1'b1;
`else
      localparam bit STORE_R = (k != DW - 1);
`endif
      pipe_div_stage #(
        .DW      (DW),
        .VW      (VW),
        .TW      (TW),
        .IDX     (k),
        .STORE_R (STORE_R)
      ) u_stage (
        .clk          (clk),
        .rst_n        (rst_n),
        .adv          (adv),
        .in_valid     (vld[k]),
        .in_r         (rem[k]),
        .in_dividend  (dvd[k]),
        .in_divisor   (dvs[k]),
        .in_quot      (quo[k]),
        .in_div0      (dz[k]),
        .in_tag       (tag[k]),
        .out_valid    (vld[k+1]),
        .out_r        (rem[k+1]),
        .out_dividend (dvd[k+1]),
        .out_divisor  (dvs[k+1]),
        .out_quot     (quo[k+1]),
        .out_div0     (dz[k+1]),
        .out_tag      (tag[k+1])
      );
    end
  endgenerate

  assign out_valid    = vld[DW];
  assign out_quotient = quo[DW];
`ifdef PIPE_DIV_REM_EN
  assign out_remainder = rem[DW];
`endif
  assign out_div0     = dz[DW];
  assign out_tag      = tag[DW];

endmodule

// File: tb/tb_pipe_divider.sv
// Scoreboard bench for pipe_divider: stimulus pushes expected results, an
// independent monitor pops and compares whenever a result is taken.
module tb_pipe_divider;
  import pipe_div_pkg::*;

  localparam int DW = PIPE_DIV_DW;
  localparam int VW = PIPE_DIV_VW;
  localparam int TW = PIPE_DIV_TW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dividend;
  logic [VW-1:0] in_divisor;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_quotient;
`ifdef PIPE_DIV_REM_EN
  logic [VW-1:0] out_remainder;
`endif
  logic          out_div0;
  logic [TW-1:0] out_tag;

  pipe_divider #(.DW(DW), .VW(VW), .TW(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
`ifdef PIPE_DIV_REM_EN
    .out_remainder(out_remainder),
`endif
    .out_div0     (out_div0),
    .out_tag      (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          div0;
    logic [TW-1:0] tag;
    int            acc_cyc;
    bit            lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: plain integer division, with the defined divide-by-zero result.
  task automatic model(input logic [DW-1:0] d, input logic [VW-1:0] v,
                       output logic [DW-1:0] q, output logic [VW-1:0] r, output logic div0);
    if (v == '0) begin
      q = '1;
      r = d[VW-1:0];
      div0 = 1'b1;
    end else begin
      q = d / DW'(v);
      r = VW'(d % DW'(v));
      div0 = 1'b0;
    end
  endtask

  // Called at a negedge; returns at a negedge after the op is accepted.
  task automatic send(input logic [DW-1:0] d, input logic [VW-1:0] v, input logic [TW-1:0] t,
                      input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ed,
                      input bit lat);
    exp_t e;
    bit   acc;
    int   waited = 0;
    in_valid = 1'b1;
    in_dividend = d;
    in_divisor = v;
    in_tag = t;
    forever begin
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        e.q = eq; e.r = er; e.div0 = ed; e.tag = t;
        e.acc_cyc = cyc; e.lat = lat;
        sb.push_back(e);
        break;
      end
      waited++;
      if (waited > 200) begin
        fail_now("send_timeout");
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [TW-1:0] t, input bit lat);
    logic [DW-1:0] d, q;
    logic [VW-1:0] v, r;
    logic          z;
    d = DW'($urandom_range(0, (1 << DW) - 1));
    v = VW'($urandom_range(0, (1 << VW) - 1));
    model(d, v, q, r, z);
    send(d, v, t, q, r, z, lat);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_idle(input string tag_name);
    check({tag_name, "_valid"}, 64'(out_valid), 64'd0);
    check({tag_name, "_quot"}, 64'(out_quotient), 64'd0);
`ifdef PIPE_DIV_REM_EN
    check({tag_name, "_rem"}, 64'(out_remainder), 64'd0);
`endif
    check({tag_name, "_div0"}, 64'(out_div0), 64'd0);
    check({tag_name, "_tag"}, 64'(out_tag), 64'd0);
    check({tag_name, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Monitor: compares taken results and checks stall behaviour.
  logic [DW-1:0] held_q;
  logic [TW-1:0] held_tag;
  logic          held_div0;
  bit            prev_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_quot", 64'(out_quotient), 64'(held_q));
        check("hold_tag", 64'(out_tag), 64'(held_tag));
        check("hold_div0", 64'(out_div0), 64'(held_div0));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = sb.pop_front();
          check("quotient", 64'(out_quotient), 64'(e.q));
`ifdef PIPE_DIV_REM_EN
          check("remainder", 64'(out_remainder), 64'(e.r));
`endif
          check("div0", 64'(out_div0), 64'(e.div0));
          check("tag", 64'(out_tag), 64'(e.tag));
          if (e.lat) check("latency", 64'(cyc - e.acc_cyc), 64'(DW));
        end
      end
      if (out_valid && !out_ready) begin
        stall_cnt++;
        check("in_ready_stall", 64'(in_ready), 64'd0);
      end
      prev_stall = out_valid && !out_ready;
      held_q     = out_quotient;
      held_tag   = out_tag;
      held_div0  = out_div0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_dividend = '0;
    in_divisor = '0;
    in_tag = '0;
    out_ready = 1'b1;
    #12;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single op, latency measured.
    send(16'd1000, 8'd7, 4'd1, 16'd142, 8'd6, 1'b0, 1'b1);
    drain();

    // Boundary values and divide by zero, back to back.
    send(16'd65535, 8'd255, 4'd2, 16'd257,   8'd0,   1'b0, 1'b1);
    send(16'd5,     8'd10,  4'd4, 16'd0,     8'd5,   1'b0, 1'b1);
    send(16'd65535, 8'd1,   4'd6, 16'd65535, 8'd0,   1'b0, 1'b1);
    send(16'd1234,  8'd0,   4'd3, 16'hFFFF,  8'hD2,  1'b1, 1'b1);
    drain();

    // 64 back-to-back ops; fixed latency on each proves one result per cycle.
    for (int i = 0; i < 64; i++) send_rand(TW'(i), 1'b1);
    drain();

    // Backpressure: drop out_ready for 3 cycles while results are flowing.
    stall_cnt = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) send_rand(TW'(i), 1'b0);
      end
      begin
        for (int i = 0; i < 100; i++) begin
          @(posedge clk);
          #1;
          if (out_valid) break;
        end
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_cycles", 64'(stall_cnt), 64'd3);

    // Reset with 10 ops in flight discards them all.
    for (int i = 0; i < 10; i++) send_rand(TW'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'd100, 8'd9, 4'd5, 16'd11, 8'd1, 1'b0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
